slice_serializer: RTL and testbench

SLICE_SERIALIZER -- requirements
Module: slice_serializer

---
 rtl/selector_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/slice_serializer.sv | 100 ++++++++++
 tb/tb_slice_serializer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/selector_pkg.sv
// Shared definitions for the slice serializer: FSM state encoding and the
// width helper used to size channel and slice indices.
package selector_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Index width for n items, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, with priority starting
// at the channel after the most recently granted one.
module rr_arbiter
    import selector_pkg::*;
#(
    parameter int N_CH = 2
) (
    input  logic            clk,
    input  logic            reset_L,
    input  logic [N_CH-1:0] req,
    input  logic            advance,
    output logic [N_CH-1:0] grant
);

    localparam int CH_W = clog2_min1(N_CH);

    logic [CH_W-1:0] ptr_q;
    logic [CH_W-1:0] win;
    int              idx;

    // Scan from lowest to highest priority so the highest-priority requester wins
    always_comb begin
        grant = '0;
        win   = '0;
        idx   = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                win        = CH_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (int'(win) == N_CH - 1) ? '0 : CH_W'(int'(win) + 1);
        end
    end

endmodule

// File: rtl/slice_serializer.sv
// Multi-channel word serializer: arbitrates one input word at a time and emits
// it as SLICE_W-bit slices, LSB- or MSB-slice first as chosen at capture.
module slice_serializer
    import selector_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int SLICE_W = 4,
    parameter  int N_CH    = 2,
    localparam int N_SL    = DATA_W / SLICE_W,
    localparam int CH_W    = clog2_min1(N_CH),
    localparam int SL_W    = clog2_min1(N_SL)
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH*DATA_W-1:0] in_data,
    output logic [N_CH-1:0]        in_ready,
    input  logic                   lsb_first,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SLICE_W-1:0]     out_data,
    output logic [CH_W-1:0]        out_ch,
    output logic                   out_last
);

    if (DATA_W % SLICE_W != 0) begin : g_bad_width
        $error("slice_serializer: DATA_W must be a multiple of SLICE_W");
    end

    state_t            state_q, state_d;
    logic [DATA_W-1:0] word_q;
    logic              lsb_q;
    logic [CH_W-1:0]   ch_q;
    logic [SL_W-1:0]   cnt_q;
    logic [N_CH-1:0]   req, grant;
    logic [CH_W-1:0]   grant_idx;
    logic              can_accept, word_xfer, slice_xfer;
    int                sel;

    assign out_valid  = (state_q == SHIFT);
    assign out_last   = out_valid && (cnt_q == SL_W'(N_SL - 1));
    assign slice_xfer = out_valid && out_ready;
    // Accept a new word when idle, or in the same cycle the last slice leaves
    assign can_accept = reset_L && ((state_q == IDLE) || (out_last && out_ready));
    assign req        = in_valid & {N_CH{can_accept}};
    assign in_ready   = grant;
    assign word_xfer  = |grant;
    assign out_ch     = ch_q;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .clk     (clk),
        .reset_L (reset_L),
        .req     (req),
        .advance (word_xfer),
        .grant   (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (grant[c]) grant_idx = CH_W'(c);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (word_xfer) state_d = SHIFT;
            SHIFT:   if (slice_xfer && out_last && !word_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            word_q <= '0;
            lsb_q  <= 1'b0;
            ch_q   <= '0;
            cnt_q  <= '0;
        end else if (word_xfer) begin
            word_q <= in_data[int'(grant_idx)*DATA_W +: DATA_W];
            lsb_q  <= lsb_first;
            ch_q   <= grant_idx;
            cnt_q  <= '0;
        end else if (slice_xfer) begin
            cnt_q  <= out_last ? '0 : cnt_q + SL_W'(1);
        end
    end

    always_comb begin
        sel      = lsb_q ? int'(cnt_q) : (N_SL - 1 - int'(cnt_q));
        out_data = word_q[sel*SLICE_W +: SLICE_W];
    end

endmodule

// File: tb/tb_slice_serializer.sv
// Directed self-checking bench for slice_serializer: default 32/4/2 instance
// plus a narrow 8/8/3 instance for the one-slice-per-word case.
module tb_slice_serializer;

    logic        clk = 1'b0;
    logic        reset_L = 1'b1;

    logic [1:0]  in_valid = '0;
    logic [63:0] in_data = '0;
    logic [1:0]  in_ready;
    logic        lsb_first = 1'b1;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_data;
    logic [0:0]  out_ch;
    logic        out_last;

    logic [2:0]  in_valid2 = '0;
    logic [23:0] in_data2 = '0;
    logic [2:0]  in_ready2;
    logic        out_valid2;
    logic [7:0]  out_data2;
    logic [1:0]  out_ch2;
    logic        out_last2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    slice_serializer dut (
        .clk(clk), .reset_L(reset_L),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .lsb_first(lsb_first),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last)
    );

    slice_serializer #(.DATA_W(8), .SLICE_W(8), .N_CH(3)) dut2 (
        .clk(clk), .reset_L(reset_L),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .lsb_first(1'b1),
        .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
        .out_ch(out_ch2), .out_last(out_last2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_L = 1'b0;
        step();
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 2'b11;
        reset_L  = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, out_ch, out_data} !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b exp 0", {out_valid, out_last, out_ch, out_data});
        end
        checks++;
        if (in_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %b exp 00", in_ready);
        end
        step();
        in_valid = 2'b00;
        reset_L  = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_valid got %b exp 0", out_valid);
        end
    endtask

    // Capture one ch0 word, then watch all 8 slices; lsb_first is flipped after capture
    task automatic run_word(input logic lsb, input logic [3:0] exp [8], input string name);
        in_data[31:0] = 32'h12345678;
        lsb_first     = lsb;
        in_valid      = 2'b01;
        #1;
        checks++;
        if (in_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL %s_grant got %b exp 01", name, in_ready);
        end
        step();
        in_valid  = 2'b00;
        lsb_first = ~lsb;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if ({out_valid, out_last, out_ch, out_data} !== {1'b1, (k == 7), 1'b0, exp[k]}) begin
                errors++;
                $display("[TB] FAIL %s_slice%0d got v%b l%b ch%0d d%h exp v1 l%b ch0 d%h",
                         name, k, out_valid, out_last, out_ch, out_data, (k == 7), exp[k]);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_idle got %b exp 0", name, out_valid);
        end
        lsb_first = 1'b1;
    endtask

    task automatic test_lsb_first();
        logic [3:0] exp [8] = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        run_word(1'b1, exp, "lsb_first");
    endtask

    task automatic test_msb_first();
        logic [3:0] exp [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        run_word(1'b0, exp, "msb_first");
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_rdy;
        apply_reset();
        in_data  = {32'h55555555, 32'hAAAAAAAA};
        in_valid = 2'b11;
        #1;
        checks++;
        if (in_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL b2b_first_grant got %b exp 01", in_ready);
        end
        step();
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 8; k++) begin
                if (w == 3 && k == 7) in_valid = 2'b00;
                #1;
                exp_rdy = (k != 7 || w == 3) ? 2'b00 : ((w % 2 == 0) ? 2'b10 : 2'b01);
                checks++;
                if ({out_valid, out_last, out_ch, out_data, in_ready} !==
                    {1'b1, (k == 7), 1'(w % 2), ((w % 2 == 0) ? 4'hA : 4'h5), exp_rdy}) begin
                    errors++;
                    $display("[TB] FAIL b2b_w%0d_s%0d got v%b l%b ch%0d d%h rdy%b exp ch%0d rdy%b",
                             w, k, out_valid, out_last, out_ch, out_data, in_ready, w % 2, exp_rdy);
                end
                step();
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_drain got %b exp 0", out_valid);
        end
    endtask

    task automatic test_stall();
        logic [3:0] exp [8] = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        int k = 0;
        in_data[63:32] = 32'h12345678;
        lsb_first      = 1'b1;
        in_valid       = 2'b10;
        step();
        in_valid = 2'b00;
        for (int c = 0; c < 11; c++) begin
            out_ready = !(c >= 4 && c < 7);
            #1;
            checks++;
            if ({out_valid, out_last, out_ch, out_data} !== {1'b1, (k == 7), 1'b1, exp[k]}) begin
                errors++;
                $display("[TB] FAIL stall_c%0d got v%b l%b ch%0d d%h exp v1 l%b ch1 d%h",
                         c, out_valid, out_last, out_ch, out_data, (k == 7), exp[k]);
            end
            if (out_ready) k++;
            step();
        end
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_drain got %b exp 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_word();
        in_data[31:0] = 32'h12345678;
        in_valid      = 2'b01;
        step();
        in_valid = 2'b00;
        for (int k = 0; k < 5; k++) step();
        #1;
        checks++;
        if (out_data !== 4'h3) begin
            errors++;
            $display("[TB] FAIL midword_slice5 got %h exp 3", out_data);
        end
        in_valid = 2'b11;
        reset_L  = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, out_ch, out_data, in_ready} !== 9'd0) begin
            errors++;
            $display("[TB] FAIL async_reset got %b exp 0", {out_valid, out_last, out_ch, out_data, in_ready});
        end
        step();
        in_data  = {32'h0, 32'hCAFEBABE};
        reset_L  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL post_reset_priority got %b exp 01", in_ready);
        end
        step();
        in_valid = 2'b00;
        #1;
        checks++;
        if ({out_valid, out_last, out_ch, out_data} !== {1'b1, 1'b0, 1'b0, 4'hE}) begin
            errors++;
            $display("[TB] FAIL post_reset_slice0 got v%b l%b ch%0d d%h exp v1 l0 ch0 dE",
                     out_valid, out_last, out_ch, out_data);
        end
        for (int k = 0; k < 8; k++) step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_drain got %b exp 0", out_valid);
        end
    endtask

    task automatic test_one_slice_per_word();
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        logic [2:0] exp_rdy;
        in_data2  = {8'h33, 8'h22, 8'h11};
        in_valid2 = 3'b111;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) in_valid2 = 3'b000;
            #1;
            exp_rdy = (i == 4) ? 3'b000 : 3'(1 << (i % 3));
            checks++;
            if (in_ready2 !== exp_rdy) begin
                errors++;
                $display("[TB] FAIL narrow_grant%0d got %b exp %b", i, in_ready2, exp_rdy);
            end
            if (i > 0) begin
                checks++;
                if ({out_valid2, out_last2, out_ch2, out_data2} !==
                    {1'b1, 1'b1, 2'((i - 1) % 3), exp_d[(i - 1) % 3]}) begin
                    errors++;
                    $display("[TB] FAIL narrow_word%0d got v%b l%b ch%0d d%h exp ch%0d d%h",
                             i, out_valid2, out_last2, out_ch2, out_data2, (i - 1) % 3, exp_d[(i - 1) % 3]);
                end
            end
            step();
        end
        checks++;
        if (out_valid2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL narrow_drain got %b exp 0", out_valid2);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_one_slice_per_word();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
